// File: rtl/poly_piano_engine.sv
// poly_piano_engine: debounced note and octave keys driving NUM_VOICES square-wave
// tone generators, mixed into a single-bit delta-sigma speaker stream.
module poly_piano_engine #(
  parameter int NUM_KEYS     = 7,
  parameter int NUM_VOICES   = 3,
  parameter int HP_W         = 20,
  parameter logic [NUM_KEYS*HP_W-1:0] NOTE_HP = {20'd101239, 20'd113636, 20'd127551,
                                                 20'd143173, 20'd151686, 20'd170262,
                                                 20'd191113},
  parameter int OCT_MAX      = 2,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_KEYS-1:0]     i_keyIn,
  input  logic [1:0]              i_octaveKeys,
  output logic signed [2:0]       o_octave,
  output logic [NUM_VOICES-1:0]   o_voiceActive,
  output logic [NUM_VOICES-1:0]   o_voiceWave,
  output logic                    o_speaker
);

  localparam int NUM_IN = NUM_KEYS + 2;
  localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int ACC_W  = $clog2(2 * NUM_VOICES);
  localparam int MIX_W  = $clog2(NUM_VOICES + 1);
  localparam logic signed [2:0] OCT_HI = 3'(OCT_MAX);
  localparam logic signed [2:0] OCT_LO = 3'(-OCT_MAX);

  logic [NUM_IN-1:0]      r_sync1;
  logic [NUM_IN-1:0]      r_sync2;
  logic [NUM_IN-1:0]      r_stable;
  logic [DEB_W-1:0]       r_debCnt [NUM_IN];
  logic [1:0]             r_prevOct;

  logic signed [2:0]      r_octave;
  logic signed [2:0]      w_octNext;
  logic [2:0]             w_octMag;
  logic                   w_upRise;
  logic                   w_dnRise;
  logic                   w_octChange;

  logic [HP_W-1:0]        w_keyShift [NUM_KEYS];
  logic [HP_W-1:0]        w_keyHp [NUM_KEYS];

  int                     w_allocCount;
  logic [NUM_VOICES-1:0]  w_newActive;
  logic [KEY_W-1:0]       w_newKey [NUM_VOICES];
  logic [NUM_VOICES-1:0]  r_voiceActive;
  logic [KEY_W-1:0]       r_voiceKey [NUM_VOICES];
  logic [HP_W-1:0]        w_voiceHp [NUM_VOICES];
  logic [HP_W-1:0]        r_voiceCnt [NUM_VOICES];
  logic [NUM_VOICES-1:0]  r_voiceWave;

  logic [MIX_W-1:0]       w_mix;
  logic [ACC_W-1:0]       w_sum;
  logic [ACC_W-1:0]       r_acc;
  logic                   r_speaker;

  // Octave keys sit above the note keys so one synchroniser/debouncer bank covers all inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_stable  <= '0;
      r_prevOct <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        r_debCnt[i] <= '0;
      end
    end else begin
      r_sync1   <= {i_octaveKeys, i_keyIn};
      r_sync2   <= r_sync1;
      r_prevOct <= r_stable[NUM_KEYS +: 2];
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_debCnt[i] <= '0;
        end else if (r_debCnt[i] == DEB_W'(DEBOUNCE_CYC - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_debCnt[i] <= '0;
        end else begin
          r_debCnt[i] <= r_debCnt[i] + DEB_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_upRise  = r_stable[NUM_KEYS] & ~r_prevOct[0];
    w_dnRise  = r_stable[NUM_KEYS+1] & ~r_prevOct[1];
    w_octNext = r_octave;
    if (w_upRise && !w_dnRise && (r_octave < OCT_HI)) begin
      w_octNext = r_octave + 3'sd1;
    end else if (w_dnRise && !w_upRise && (r_octave > OCT_LO)) begin
      w_octNext = r_octave - 3'sd1;
    end
    w_octChange = (w_octNext != r_octave);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_octave <= '0;
    end else begin
      r_octave <= w_octNext;
    end
  end

  assign w_octMag = r_octave[2] ? -r_octave : r_octave;

  // Negative octaves lengthen the half-period; overflow past HP_W bits is simply dropped.
  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (r_octave[2]) begin
        w_keyShift[k] = NOTE_HP[k*HP_W +: HP_W] << w_octMag;
      end else begin
        w_keyShift[k] = NOTE_HP[k*HP_W +: HP_W] >> w_octMag;
      end
      w_keyHp[k] = (w_keyShift[k] < HP_W'(2)) ? HP_W'(2) : w_keyShift[k];
    end
  end

  // Voice v picks up the v-th lowest pressed key; surplus keys are dropped.
  always_comb begin
    w_allocCount = 0;
    w_newActive  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_newKey[v] = '0;
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (r_stable[k]) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (w_allocCount == v) begin
            w_newActive[v] = 1'b1;
            w_newKey[v]    = KEY_W'(k);
          end
        end
        w_allocCount = w_allocCount + 1;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_voiceHp[v] = HP_W'(2);
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (r_voiceKey[v] == KEY_W'(k)) begin
          w_voiceHp[v] = w_keyHp[k];
        end
      end
    end
  end

  // Any change of assignment, activation or octave restarts the tone from a low phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_voiceActive <= '0;
      r_voiceWave   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voiceKey[v] <= '0;
        r_voiceCnt[v] <= '0;
      end
    end else begin
      r_voiceActive <= w_newActive;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_voiceKey[v] <= w_newKey[v];
        if (!w_newActive[v] || w_octChange || !r_voiceActive[v] ||
            (w_newKey[v] != r_voiceKey[v])) begin
          r_voiceCnt[v]  <= '0;
          r_voiceWave[v] <= 1'b0;
        end else if (r_voiceCnt[v] == (w_voiceHp[v] - HP_W'(1))) begin
          r_voiceCnt[v]  <= '0;
          r_voiceWave[v] <= ~r_voiceWave[v];
        end else begin
          r_voiceCnt[v]  <= r_voiceCnt[v] + HP_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_mix = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_mix = w_mix + MIX_W'(r_voiceWave[v]);
    end
  end

  assign w_sum = r_acc + ACC_W'(w_mix);

  // First-order delta-sigma: emit a one whenever the accumulator reaches full scale.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc     <= '0;
      r_speaker <= 1'b0;
    end else if (w_sum >= ACC_W'(NUM_VOICES)) begin
      r_acc     <= w_sum - ACC_W'(NUM_VOICES);
      r_speaker <= 1'b1;
    end else begin
      r_acc     <= w_sum;
      r_speaker <= 1'b0;
    end
  end

  assign o_octave      = r_octave;
  assign o_voiceActive = r_voiceActive;
  assign o_voiceWave   = r_voiceWave;
  assign o_speaker     = r_speaker;

endmodule

// File: tb/tb_poly_piano_engine.sv
// tb_poly_piano_engine: directed and randomized key stimulus checked each cycle
// against a time-based behavioural model of the piano engine.
module tb_poly_piano_engine;

  localparam int NK      = 7;
  localparam int NV      = 3;
  localparam int DEB     = 4;
  localparam int OCT_MAX = 2;

  logic            clk;
  logic            rst_n;
  logic [NK-1:0]   keyIn;
  logic [1:0]      octaveKeys;
  logic signed [2:0] octave;
  logic [NV-1:0]   voiceActive;
  logic [NV-1:0]   voiceWave;
  logic            speaker;

  int checkCount;
  int failCount;

  // Model state: pipelines and debounce as the rules describe, tones as a function of time.
  int   hpTable [NK] = '{8, 10, 11, 12, 13, 14, 15};
  logic [NK+1:0] mSync1, mSync2, mStable;
  int   mDeb [NK+2];
  bit   mPrevUp, mPrevDn;
  int   mOct;
  bit   mAct [NV];
  int   mKey [NV];
  int   mTrig [NV];
  int   mHp [NV];
  bit   mWave [NV];
  int   mAcc;
  bit   mSpk;
  int   mCycle;

  poly_piano_engine #(
    .NUM_KEYS(NK),
    .NUM_VOICES(NV),
    .HP_W(20),
    .NOTE_HP({20'd15, 20'd14, 20'd13, 20'd12, 20'd11, 20'd10, 20'd8}),
    .OCT_MAX(OCT_MAX),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_keyIn(keyIn),
    .i_octaveKeys(octaveKeys),
    .o_octave(octave),
    .o_voiceActive(voiceActive),
    .o_voiceWave(voiceWave),
    .o_speaker(speaker)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int hpOf(input int k, input int oct);
    longint h;
    h = hpTable[k];
    if (oct >= 0) h = h / (longint'(1) << oct);
    else h = (h * (longint'(1) << (-oct))) % (longint'(1) << 20);
    if (h < 2) h = 2;
    return int'(h);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: observed %0h expected %0h",
               tag, mCycle, observed, expected);
    end
  endtask

  task automatic modelReset();
    mSync1 = '0; mSync2 = '0; mStable = '0;
    mPrevUp = 0; mPrevDn = 0; mOct = 0; mAcc = 0; mSpk = 0;
    for (int i = 0; i < NK + 2; i++) mDeb[i] = 0;
    for (int v = 0; v < NV; v++) begin
      mAct[v] = 0; mKey[v] = 0; mTrig[v] = 0; mHp[v] = 2; mWave[v] = 0;
    end
  endtask

  task automatic modelStep(input logic [NK+1:0] raw);
    logic [NK+1:0] nStable;
    int  nDeb [NK+2];
    int  nOct;
    int  pressed [$];
    int  oldMix;
    int  s;
    int  newKey;
    bit  newAct;
    bit  up, dn;
    mCycle++;
    nStable = mStable;
    for (int i = 0; i < NK + 2; i++) begin
      if (mSync2[i] !== mStable[i]) begin
        if (mDeb[i] + 1 >= DEB) begin
          nStable[i] = mSync2[i];
          nDeb[i] = 0;
        end else begin
          nDeb[i] = mDeb[i] + 1;
        end
      end else begin
        nDeb[i] = 0;
      end
    end
    up = mStable[NK] && !mPrevUp;
    dn = mStable[NK+1] && !mPrevDn;
    nOct = mOct;
    if (up && !dn) nOct = (mOct + 1 > OCT_MAX) ? OCT_MAX : mOct + 1;
    else if (dn && !up) nOct = (mOct - 1 < -OCT_MAX) ? -OCT_MAX : mOct - 1;
    for (int k = 0; k < NK; k++) if (mStable[k]) pressed.push_back(k);
    oldMix = 0;
    for (int v = 0; v < NV; v++) oldMix += int'(mWave[v]);
    for (int v = 0; v < NV; v++) begin
      newAct = (v < pressed.size());
      newKey = newAct ? pressed[v] : 0;
      if (!newAct) begin
        mWave[v] = 0;
      end else if (nOct != mOct || !mAct[v] || newKey != mKey[v]) begin
        mTrig[v] = mCycle;
        mHp[v]   = hpOf(newKey, nOct);
        mWave[v] = 0;
      end else begin
        mWave[v] = (((mCycle - mTrig[v]) / mHp[v]) % 2) == 1;
      end
      mAct[v] = newAct;
      mKey[v] = newKey;
    end
    s = mAcc + oldMix;
    if (s >= NV) begin
      mSpk = 1; mAcc = s - NV;
    end else begin
      mSpk = 0; mAcc = s;
    end
    mPrevUp = mStable[NK];
    mPrevDn = mStable[NK+1];
    mSync2  = mSync1;
    mSync1  = raw;
    mStable = nStable;
    for (int i = 0; i < NK + 2; i++) mDeb[i] = nDeb[i];
    mOct = nOct;
  endtask

  task automatic compareAll();
    logic [NV-1:0] expAct, expWave;
    logic [2:0]    expOct;
    for (int v = 0; v < NV; v++) begin
      expAct[v]  = mAct[v];
      expWave[v] = mWave[v];
    end
    expOct = 3'(mOct);
    checkOutput("octave", {29'b0, octave}, {29'b0, expOct});
    checkOutput("voiceActive", {29'b0, voiceActive}, {29'b0, expAct});
    checkOutput("voiceWave", {29'b0, voiceWave}, {29'b0, expWave});
    checkOutput("speaker", {31'b0, speaker}, {31'b0, mSpk});
  endtask

  // Called at a negedge: drives inputs, then runs the DUT and model for the given edges.
  task automatic applyStimulus(input logic [NK-1:0] keys, input logic [1:0] oct,
                               input int cycles);
    keyIn      = keys;
    octaveKeys = oct;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      modelStep({oct, keys});
      @(negedge clk);
      compareAll();
    end
  endtask

  initial begin
    int expOct [8] = '{1, 2, 2, 1, 0, -1, -2, -2};
    logic [2:0] octBits;
    logic [NK-1:0] rk;
    logic [1:0] ro;
    int r;
    checkCount = 0;
    failCount  = 0;
    mCycle     = 0;
    keyIn      = '0;
    octaveKeys = '0;
    rst_n      = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #20;
    checkOutput("resetOctave", {29'b0, octave}, 32'd0);
    checkOutput("resetActive", {29'b0, voiceActive}, 32'd0);
    checkOutput("resetWave", {29'b0, voiceWave}, 32'd0);
    checkOutput("resetSpeaker", {31'b0, speaker}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Key 0 alone: activation latency and first toggle.
    applyStimulus(7'b0000001, 2'b00, 6);
    checkOutput("activeBeforeLatency", {29'b0, voiceActive}, 32'd0);
    applyStimulus(7'b0000001, 2'b00, 1);
    checkOutput("activeKey0", {29'b0, voiceActive}, 32'd1);
    applyStimulus(7'b0000001, 2'b00, 7);
    checkOutput("waveBeforeToggle", {29'b0, voiceWave}, 32'd0);
    applyStimulus(7'b0000001, 2'b00, 1);
    checkOutput("waveFirstToggle", {29'b0, voiceWave}, 32'd1);
    applyStimulus(7'b0000001, 2'b00, 40);
    applyStimulus(7'b0000000, 2'b00, 12);

    // Short glitch rejected, four-cycle hold accepted.
    applyStimulus(7'b0000100, 2'b00, 3);
    applyStimulus(7'b0000000, 2'b00, 12);
    checkOutput("glitchIgnored", {29'b0, voiceActive}, 32'd0);
    applyStimulus(7'b0000100, 2'b00, 4);
    applyStimulus(7'b0000000, 2'b00, 3);
    checkOutput("holdAccepted", {29'b0, voiceActive}, 32'd1);
    applyStimulus(7'b0000000, 2'b00, 12);

    // Four keys for three voices, then release of a middle key.
    applyStimulus(7'b1011010, 2'b00, 30);
    checkOutput("threeVoices", {29'b0, voiceActive}, 32'd7);
    applyStimulus(7'b1010010, 2'b00, 30);
    applyStimulus(7'b0000000, 2'b00, 12);

    // Octave up x3 then down x5 with key 0 sounding.
    applyStimulus(7'b0000001, 2'b00, 12);
    for (int p = 0; p < 8; p++) begin
      applyStimulus(7'b0000001, (p < 3) ? 2'b01 : 2'b10, 8);
      applyStimulus(7'b0000001, 2'b00, 8);
      octBits = 3'(expOct[p]);
      checkOutput("octaveStep", {29'b0, octave}, {29'b0, octBits});
      applyStimulus(7'b0000001, 2'b00, 60);
    end

    // Simultaneous up and down leaves the octave alone.
    applyStimulus(7'b0000001, 2'b11, 10);
    applyStimulus(7'b0000001, 2'b00, 10);
    checkOutput("octaveBothKeys", {29'b0, octave}, {29'b0, 3'b110});

    // Three voices at low pitch so all waves overlap high.
    applyStimulus(7'b0000111, 2'b00, 250);

    // Asynchronous reset mid-tone.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncResetOctave", {29'b0, octave}, 32'd0);
    checkOutput("asyncResetActive", {29'b0, voiceActive}, 32'd0);
    checkOutput("asyncResetWave", {29'b0, voiceWave}, 32'd0);
    checkOutput("asyncResetSpeaker", {31'b0, speaker}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized key and octave activity.
    for (int it = 0; it < 300; it++) begin
      rk = NK'($urandom_range(0, 127));
      if ($urandom_range(0, 4) == 0) rk = '0;
      r = $urandom_range(0, 11);
      ro = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      applyStimulus(rk, ro, $urandom_range(1, 12));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
